pc_fetch: RTL and testbench

Instruction-fetch stage and program-counter owner for the 16-bit pipeline. Holds the PC, drives the instruction-memory address, and loads the IF/ID pipeline register. Consumes the branch redirect (`set_pc`, `set_pc_value`) that the ID-stage branch resolver produces. Squashes the wrong-path fetch and counts fetch and redirect events for debug.

---
 rtl/pc_fetch_pkg.sv | 21 ++
 rtl/pc_fetch_perf_cnt.sv | 31 +++
 rtl/pc_fetch.sv | 121 ++++++++++++
 tb/tb_pc_fetch.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared widths, constants and the per-cycle action type
// used by the instruction-fetch stage.
package pc_fetch_pkg;

  localparam int unsigned REG_W = 16;

  // Instruction inserted into IF/ID whenever the stage emits a bubble.
  localparam logic [REG_W-1:0] NOP_INSTR = 16'h0800;

  // Default value for the RESET_PC parameter of pc_fetch.
  localparam logic [REG_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  // What the fetch stage does on the coming clock edge.
  typedef enum logic [1:0] {
    ACT_FETCH  = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2,
    ACT_REDIR  = 2'd3
  } fetch_act_e;

endpackage

// File: rtl/pc_fetch_perf_cnt.sv
// fetch_perf_cnt: 16-bit free-running event counter that wraps at 16'hFFFF.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset, clears the count
//   inc  - count one event on this edge
//   cnt  - current count (registered)
module fetch_perf_cnt
  import pc_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [REG_W-1:0] cnt
);

  logic [REG_W-1:0] cnt_r;

  // Event counter register; modulo-2^16 increment, no saturation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 16'h0000;
    end else if (inc) begin
      cnt_r <= cnt_r + 16'h0001;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: instruction-fetch stage. Owns the PC, drives the asynchronous
// instruction SRAM address, loads the IF/ID register and takes branch
// redirects from the ID-stage resolver.
// Ports:
//   clk, rst            - clock and asynchronous active-high reset
//   set_pc, set_pc_value- redirect request and target (ignored while stalled)
//   stall               - ID hazard, freezes PC, IF/ID and counters
//   mem_busy            - SRAM owned by MEM this cycle, bubble into IF/ID
//   imem_addr, imem_req - fetch address (== pc) and fetch-performed strobe
//   imem_data           - instruction word for imem_addr, same cycle
//   if_pc, if_opn,
//   if_valid            - IF/ID register: fetched address + 1, instruction,
//                         real-instruction flag
//   fetch_cnt,
//   redirect_cnt        - debug event counters
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [REG_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_pc,
  input  logic [REG_W-1:0] set_pc_value,
  input  logic             stall,
  input  logic             mem_busy,
  output logic [REG_W-1:0] imem_addr,
  output logic             imem_req,
  input  logic [REG_W-1:0] imem_data,
  output logic [REG_W-1:0] if_pc,
  output logic [REG_W-1:0] if_opn,
  output logic             if_valid,
  output logic [REG_W-1:0] fetch_cnt,
  output logic [REG_W-1:0] redirect_cnt
);

  logic [REG_W-1:0] pc_r;
  logic [REG_W-1:0] if_pc_r;
  logic [REG_W-1:0] if_opn_r;
  logic             if_valid_r;
  logic             redir_s;
  fetch_act_e       act_s;

  // A redirect seen during a stall is dropped, not deferred: the branch
  // stays in ID and is resolved again once the stall clears.
  assign redir_s = set_pc & ~stall;

  // Priority decode of the action for the coming edge.
  always_comb begin
    act_s = ACT_FETCH;
    if (redir_s) begin
      act_s = ACT_REDIR;
    end else if (stall) begin
      act_s = ACT_HOLD;
    end else if (mem_busy) begin
      act_s = ACT_BUBBLE;
    end else begin
      act_s = ACT_FETCH;
    end
  end

  assign imem_addr = pc_r;
  assign imem_req  = ~rst & (act_s == ACT_FETCH);

  // PC and IF/ID register update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      if_pc_r    <= 16'h0000;
      if_opn_r   <= NOP_INSTR;
      if_valid_r <= 1'b0;
    end else begin
      case (act_s)
        ACT_REDIR: begin
          pc_r       <= set_pc_value;
          if_pc_r    <= 16'h0000;
          if_opn_r   <= NOP_INSTR;
          if_valid_r <= 1'b0;
        end
        ACT_BUBBLE: begin
          // ID advances while IF cannot fetch, so ID must see a NOP.
          pc_r       <= pc_r;
          if_pc_r    <= 16'h0000;
          if_opn_r   <= NOP_INSTR;
          if_valid_r <= 1'b0;
        end
        ACT_FETCH: begin
          pc_r       <= pc_r + 16'h0001;
          if_pc_r    <= pc_r + 16'h0001;
          if_opn_r   <= imem_data;
          if_valid_r <= 1'b1;
        end
        default: begin
          pc_r       <= pc_r;
          if_pc_r    <= if_pc_r;
          if_opn_r   <= if_opn_r;
          if_valid_r <= if_valid_r;
        end
      endcase
    end
  end

  assign if_pc    = if_pc_r;
  assign if_opn   = if_opn_r;
  assign if_valid = if_valid_r;

  fetch_perf_cnt u_fetch_cnt (
    .clk (clk),
    .rst (rst),
    .inc (act_s == ACT_FETCH),
    .cnt (fetch_cnt)
  );

  fetch_perf_cnt u_redirect_cnt (
    .clk (clk),
    .rst (rst),
    .inc (act_s == ACT_REDIR),
    .cnt (redirect_cnt)
  );

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: randomized scoreboard bench for pc_fetch. The driver steps a
// behavioural model of the fetch stage and queues the expected outputs; the
// monitor pops and compares them against the DUT each cycle.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        set_pc;
  logic [15:0] set_pc_value;
  logic        stall;
  logic        mem_busy;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [15:0] imem_data;
  logic [15:0] if_pc;
  logic [15:0] if_opn;
  logic        if_valid;
  logic [15:0] fetch_cnt;
  logic [15:0] redirect_cnt;

  logic [15:0] mem [65536];
  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  pc_fetch #(.RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .set_pc       (set_pc),
    .set_pc_value (set_pc_value),
    .stall        (stall),
    .mem_busy     (mem_busy),
    .imem_addr    (imem_addr),
    .imem_req     (imem_req),
    .imem_data    (imem_data),
    .if_pc        (if_pc),
    .if_opn       (if_opn),
    .if_valid     (if_valid),
    .fetch_cnt    (fetch_cnt),
    .redirect_cnt (redirect_cnt)
  );

  typedef struct packed {
    logic        req;   // imem_req before the edge
    logic [15:0] addr;  // imem_addr before the edge
    logic [15:0] ipc;   // IF/ID state after the edge
    logic [15:0] opn;
    logic        vld;
    logic [15:0] fc;
    logic [15:0] rc;
    logic        now;   // reset asserted mid-cycle: state must already be reset
  } exp_t;

  exp_t q[$];
  bit   done = 1'b0;

  // Reference model state.
  logic [15:0] m_pc, m_ipc, m_opn, m_fc, m_rc;
  logic        m_vld;

  task automatic model_reset();
    m_pc = 16'h0000; m_ipc = 16'h0000; m_opn = 16'h0800;
    m_vld = 1'b0; m_fc = 16'h0000; m_rc = 16'h0000;
  endtask

  // Apply one cycle of stimulus, advance the model, queue the expectation.
  task automatic step(input logic r, input logic sp, input logic [15:0] tgt,
                      input logic st, input logic mb, input logic late_rst);
    exp_t e;
    @(negedge clk);
    set_pc = sp; set_pc_value = tgt; stall = st; mem_busy = mb;
    if (late_rst) begin
      rst = 1'b0;
      #1;
      rst = 1'b1;
    end else begin
      rst = r;
    end
    e.now = r | late_rst;
    if (e.now) model_reset();
    e.addr = m_pc;
    e.req  = !e.now && !st && !mb && !(sp && !st);
    if (e.now) begin
      // state stays at reset values
    end else if (sp && !st) begin
      m_pc = tgt; m_ipc = 16'h0000; m_opn = 16'h0800; m_vld = 1'b0; m_rc = m_rc + 16'd1;
    end else if (st) begin
      // everything holds
    end else if (mb) begin
      m_ipc = 16'h0000; m_opn = 16'h0800; m_vld = 1'b0;
    end else begin
      m_opn = mem[m_pc]; m_ipc = m_pc + 16'd1; m_vld = 1'b1;
      m_pc = m_pc + 16'd1; m_fc = m_fc + 16'd1;
    end
    e.ipc = m_ipc; e.opn = m_opn; e.vld = m_vld; e.fc = m_fc; e.rc = m_rc;
    q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  // Driver: directed test-plan sequences, random traffic, wrap-around run.
  initial begin
    rst = 1'b1; set_pc = 1'b0; set_pc_value = 16'h0000; stall = 1'b0; mem_busy = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
    model_reset();
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    run(5);                                              // pc reaches 5
    step(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0);        // taken branch
    run(2);
    step(1'b0, 1'b1, 16'h0123, 1'b1, 1'b0, 1'b0);        // redirect during stall
    step(1'b0, 1'b1, 16'h0123, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h0123, 1'b0, 1'b0, 1'b0);        // released: taken once
    run(1);
    step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);        // go to 0x0010
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);        // mem_busy alone
    run(1);
    step(1'b0, 1'b1, 16'h0077, 1'b0, 1'b1, 1'b0);        // mem_busy + redirect
    run(2);
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), 16'($urandom),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), 1'b0);
    end
    run(3);
    step(1'b0, 1'b1, 16'h0200, 1'b0, 1'b0, 1'b1);        // async reset mid-redirect
    run(2);
    step(1'b0, 1'b1, 16'h0300, 1'b1, 1'b0, 1'b1);        // async reset mid-stall
    // pc and fetch_cnt both wrap past 16'hFFFF
    run(65540);
    @(negedge clk);
    done = 1'b1;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares combinational fetch outputs mid-cycle and the
  // registered IF/ID and counter state just after each edge.
  initial begin
    exp_t e;
    int   idle = 0;
    while (1) begin
      @(negedge clk);
      #2;
      if (q.size() == 0) begin
        if (done) break;
        idle++;
        if (idle > 20) begin
          n_chk++; n_fail++;
          $display("FAIL timeout: no expectation queued for %0d cycles", idle);
          break;
        end
      end else begin
        idle = 0;
        e = q[0];
        chk("imem_req", {15'd0, imem_req}, {15'd0, e.req});
        chk("imem_addr", imem_addr, e.addr);
        if (e.now) begin
          chk("async_if_pc", if_pc, 16'h0000);
          chk("async_if_opn", if_opn, 16'h0800);
          chk("async_if_valid", {15'd0, if_valid}, 16'h0000);
          chk("async_fetch_cnt", fetch_cnt, 16'h0000);
          chk("async_redirect_cnt", redirect_cnt, 16'h0000);
        end
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("if_pc", if_pc, e.ipc);
        chk("if_opn", if_opn, e.opn);
        chk("if_valid", {15'd0, if_valid}, {15'd0, e.vld});
        chk("fetch_cnt", fetch_cnt, e.fc);
        chk("redirect_cnt", redirect_cnt, e.rc);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
